// File: rtl/parity_pkg.sv
// rtl/parity_pkg.sv - shared constants for the parity frame generator/checker pair
package parity_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2,
        STOP = 2'd3
    } state_t;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_CNT_W  = 8;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/par_calc.sv
// rtl/par_calc.sv - combinational XOR reduction over a data word plus parity bit
module par_calc #(
    parameter int W = 9
) (
    input  logic [W-1:0] bits,
    output logic         odd
);

    assign odd = ^bits;

endmodule

// File: rtl/parity_frame_checker.sv
// rtl/parity_frame_checker.sv - serial receiver for start/data/parity/stop frames with
// parity and framing checks and a saturating error counter
module parity_frame_checker
    import parity_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int EVEN_PARITY = 1,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sin,
    input  logic              sin_valid,
    input  logic              clr_cnt,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy,
    output logic [CNT_W-1:0]  err_count
);

    localparam int                BC_W       = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BC_W-1:0]   LAST_BIT   = BC_W'(DATA_W - 1);
    localparam logic              PAR_EXPECT = (EVEN_PARITY != 0) ? 1'b0 : 1'b1;
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

    state_t            state;
    state_t            state_nxt;
    logic [BC_W-1:0]   bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic              par_bit;
    logic              xor_all;

    logic              start_seen;
    logic              shift_en;
    logic              par_en;
    logic              frame_done;
    logic              err_now;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (sin_valid && sin == START_BIT)     state_nxt = DATA;
            DATA: if (sin_valid && bit_cnt == LAST_BIT)  state_nxt = PAR;
            PAR:  if (sin_valid)                         state_nxt = STOP;
            STOP: if (sin_valid)                         state_nxt = IDLE;
            default:                                     state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != IDLE);
        start_seen = (state == IDLE) && sin_valid && (sin == START_BIT);
        shift_en   = (state == DATA) && sin_valid;
        par_en     = (state == PAR)  && sin_valid;
        frame_done = (state == STOP) && sin_valid;
    end

    // Data enters at the MSB so the first (LSB) bit ends up in bit 0 after DATA_W shifts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
        end else begin
            if (start_seen) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (shift_en) begin
                shreg <= {sin, shreg[DATA_W-1:1]};
            end
            if (par_en) begin
                par_bit <= sin;
            end
        end
    end

    par_calc #(
        .W(DATA_W + 1)
    ) u_par_calc (
        .bits({par_bit, shreg}),
        .odd (xor_all)
    );

    assign err_now = (xor_all != PAR_EXPECT) || (sin != STOP_BIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_valid <= frame_done;
            if (frame_done) begin
                data_out   <= shreg;
                parity_err <= (xor_all != PAR_EXPECT);
                frame_err  <= (sin != STOP_BIT);
            end
        end
    end

    // Clear wins over a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (clr_cnt) begin
            err_count <= '0;
        end else if (frame_done && err_now && err_count != CNT_MAX) begin
            err_count <= err_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_parity_frame_checker.sv
// tb/tb_parity_frame_checker.sv - scoreboard bench for parity_frame_checker
module tb_parity_frame_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sin = 1'b1;
    logic       sin_valid = 1'b0;
    logic       clr_cnt = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;
    logic [7:0] err_count;

    parity_frame_checker #(
        .DATA_W(8),
        .EVEN_PARITY(1),
        .CNT_W(8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sin       (sin),
        .sin_valid (sin_valid),
        .clr_cnt   (clr_cnt),
        .data_out  (data_out),
        .data_valid(data_valid),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .busy      (busy),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        logic [7:0] cnt;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   pulses = 0;
    int   mdl_cnt = 0;
    logic prev_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && data_valid) begin
            exp_t e;
            pulses++;
            check("valid_one_cycle", {31'd0, prev_valid}, 32'd0);
            if (q.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                check("data_out", {24'd0, data_out}, {24'd0, e.d});
                check("parity_err", {31'd0, parity_err}, {31'd0, e.pe});
                check("frame_err", {31'd0, frame_err}, {31'd0, e.fe});
                check("err_count", {24'd0, err_count}, {24'd0, e.cnt});
            end
        end
        prev_valid = rst_n && data_valid;
    end

    task automatic send_bit(input logic b, input int gap);
        for (int g = 0; g < gap; g++) begin
            sin_valid = 1'b0;
            sin = 1'($urandom);
            @(posedge clk); #1;
        end
        sin_valid = 1'b1;
        sin = b;
        @(posedge clk); #1;
        sin_valid = 1'b0;
        sin = 1'b1;
    endtask

    // Sends one frame; flip_par inverts the correct even parity bit.
    task automatic send_frame(input logic [7:0] d, input logic flip_par, input logic stop,
                              input int gapmax, input logic clr_at_stop);
        exp_t e;
        logic p;
        logic err;
        p = (^d) ^ flip_par;
        err = flip_par || !stop;
        if (clr_at_stop) mdl_cnt = 0;
        else if (err && mdl_cnt != 255) mdl_cnt++;
        e.d = d; e.pe = flip_par; e.fe = !stop; e.cnt = 8'(mdl_cnt);
        q.push_back(e);
        send_bit(1'b0, $urandom_range(0, gapmax));
        for (int i = 0; i < 8; i++) send_bit(d[i], $urandom_range(0, gapmax));
        send_bit(p, $urandom_range(0, gapmax));
        clr_cnt = clr_at_stop;
        send_bit(stop, $urandom_range(0, gapmax));
        clr_cnt = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int i;
        for (i = 0; i < 50; i++) begin
            if (q.size() == 0) break;
            @(negedge clk);
        end
        check(name, q.size(), 32'd0);
    endtask

    initial begin
        int saved;
        logic [10:0] vec;
        repeat (3) @(posedge clk);
        #1;
        check("reset_data_out", {24'd0, data_out}, 32'd0);
        check("reset_valid", {31'd0, data_valid}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_err_count", {24'd0, err_count}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;

        // Clean 0xA5 as a literal bit stream: start, LSB-first data, parity, stop.
        vec = 11'b10101001010;
        q.push_back('{d: 8'hA5, pe: 1'b0, fe: 1'b0, cnt: 8'd0});
        for (int i = 0; i < 11; i++) begin
            send_bit(vec[i], 0);
            if (i == 0) check("busy_after_start", {31'd0, busy}, 32'd1);
        end
        wait_drain("drain_clean");
        check("busy_after_stop", {31'd0, busy}, 32'd0);

        send_frame(8'hA5, 1'b1, 1'b1, 0, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b0, 0, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b0, 0, 1'b0);
        wait_drain("drain_errors");

        saved = pulses;
        send_frame(8'hFF, 1'b0, 1'b1, 5, 1'b0);
        send_frame(8'h00, 1'b0, 1'b1, 0, 1'b0);
        wait_drain("drain_gapped");
        check("gapped_pulses", pulses - saved, 32'd2);

        for (int n = 0; n < 300; n++) send_frame(8'(n), 1'b1, 1'b1, 0, 1'b0);
        wait_drain("drain_saturate");
        check("saturated", {24'd0, err_count}, 32'd255);
        send_frame(8'h81, 1'b1, 1'b1, 0, 1'b1);
        wait_drain("drain_clear");
        check("cleared", {24'd0, err_count}, 32'd0);

        send_frame(8'h11, 1'b1, 1'b1, 0, 1'b0);
        wait_drain("drain_pre_reset");
        saved = pulses;
        send_bit(1'b0, 0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
        check("busy_mid_frame", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_data_out", {24'd0, data_out}, 32'd0);
        check("abort_valid", {31'd0, data_valid}, 32'd0);
        check("abort_parity_err", {31'd0, parity_err}, 32'd0);
        check("abort_frame_err", {31'd0, frame_err}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_err_count", {24'd0, err_count}, 32'd0);
        mdl_cnt = 0;
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (12) @(posedge clk); #1;
        check("no_valid_after_abort", pulses, saved);

        send_frame(8'h5A, 1'b0, 1'b1, 0, 1'b0);
        wait_drain("drain_after_reset");
        check("pulse_after_reset", pulses - saved, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/parity_frame_checker.md
# parity_frame_checker

Serial receiver and checker for 9-bit parity frames (8 data bits + 1 parity bit) produced by the team's parity generator. It sits on the receive side of a bit-serial link, framed with start and stop bits. It deserialises each frame, checks parity and framing, presents the data byte with a one-cycle valid strobe, and keeps a saturating error count.

## Interface
- `DATA_W`, default 8: data bits per frame.
- `EVEN_PARITY`, default 1: 1 means the total count of ones over data plus parity must be even; 0 means it must be odd.
- `CNT_W`, default 8: width of the error counter.
- `clk`  in  1  single system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sin`  in  1  serial line bit; the line idles high.
- `sin_valid`  in  1  qualifies `sin` for one cycle; one bit is consumed per asserted cycle.
- `clr_cnt`  in  1  synchronous clear of `err_count`.
- `data_out`  out  DATA_W  last received data byte; held until the next frame completes.
- `data_valid`  out  1  one-cycle pulse when a frame completes.
- `parity_err`  out  1  parity mismatch flag for the completed frame; valid with `data_valid`.
- `frame_err`  out  1  stop-bit-was-0 flag for the completed frame; valid with `data_valid`.
- `busy`  out  1  high while a frame is in progress (state is not IDLE).
- `err_count`  out  CNT_W  count of frames with either error flag set; saturates at all-ones.

## Operation
- Frame format, LSB first: start bit (0), DATA_W data bits, parity bit, stop bit (1).
- Bits are sampled only in cycles where `sin_valid`=1. Gaps of any length between bits are legal and do not change state.
- State machine:
  - IDLE: a valid `sin`=0 moves to DATA and clears the bit counter. A valid `sin`=1 is ignored.
  - DATA: each valid bit shifts into the shift register at the MSB end, so the byte is LSB-aligned after DATA_W bits. The counter increments; after DATA_W bits, move to PAR.
  - PAR: capture the parity bit and move to STOP.
  - STOP: on a valid bit, register all frame results, pulse `data_valid`, and return to IDLE.
- Frame results registered at STOP:
  - `data_out` = shift register contents.
  - `parity_err` = (XOR of data bits and parity bit) != (EVEN_PARITY ? 0 : 1).
  - `frame_err` = ~stop bit.
- `data_out` is updated even when an error flag is set.
- `err_count` increments by 1 when `data_valid` fires with `parity_err` or `frame_err` set. A frame with both errors counts once. The count stops at 2^CNT_W−1.
- `clr_cnt` takes priority over a same-cycle increment: the result is 0.
- Back-to-back frames are allowed: a start bit sampled in the cycle after STOP begins a new frame.

## Timing
- Reset values:
  - state: IDLE
  - `data_out`: 0
  - `data_valid`: 0
  - `parity_err`: 0
  - `frame_err`: 0
  - `busy`: 0
  - `err_count`: 0
  - internal shift register and bit counter: 0
- `data_valid`, `parity_err`, `frame_err`, and `data_out` all update on the same edge that samples the stop bit, which is one cycle after that stop bit is presented.
- `parity_err` and `frame_err` hold their values until the next `data_valid`.
- `err_count` reflects the completed frame on the same edge as `data_valid`.
- `busy` rises on the edge that samples the start bit and falls on the edge that samples the stop bit.
- Reset asserted mid-frame aborts the frame immediately: no `data_valid` pulse and no count change.
- A frame takes a minimum of DATA_W+3 valid cycles from start bit to stop bit.

## Structure
- Shared package `parity_pkg` contains:
  - the state encoding constants IDLE, DATA, PAR, STOP (2 bits);
  - the default widths;
  - the start and stop bit level constants, also used by the generator.
- Sub-module `par_calc`: a combinational parameterised XOR reduction over DATA_W+1 bits. It is shared with the generator side.
- The rest of the design (FSM, shift register, counter, error counter) lives in the top module.

## Test plan
- Clean frame: with EVEN_PARITY=1, send bits 0,1,0,1,0,0,1,0,1,0,1 on consecutive valid cycles (0xA5, parity 0) → `data_out`=8'hA5, one `data_valid` pulse, `parity_err`=0, `frame_err`=0, `err_count`=0.
- Parity error: same frame with parity bit 1 → `parity_err`=1, `data_out`=8'hA5, `err_count`=1.
- Framing error: 0x3C with correct parity 0 and stop bit 0 → `frame_err`=1, `parity_err`=0, `err_count`+1. A frame with both errors adds only 1.
- Gapped input: 0xFF frame with random 0–5 cycle gaps in `sin_valid` → single `data_valid` pulse, `data_out`=8'hFF, no errors. Then a back-to-back 0x00 frame → second pulse, `data_out`=8'h00.
- Saturation and clear: send 300 parity-error frames → `err_count`=255. Assert `clr_cnt` in the same cycle as the 301st error frame completes → `err_count`=0.
- Reset mid-frame: assert `rst_n`=0 after 4 data bits → all outputs at reset values, no `data_valid`. A clean 0x5A frame after reset is received correctly.
